// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and mem_controller port of mem_port_arbiter.
// master is the arbiter's view; slave is the view of the requesters and the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned MEM_ADDR_BITS = 16,
  parameter int unsigned XLEN          = 32
);
  logic                     fetch_req;
  logic [MEM_ADDR_BITS-1:0] fetch_addr;
  logic                     fetch_grant;
  logic                     fetch_ack;
  logic [XLEN-1:0]          fetch_data;

  logic                     data_read_en;
  logic [3:0]               data_write_en;
  logic [MEM_ADDR_BITS-1:0] data_addr;
  logic [XLEN-1:0]          data_write_data;
  logic                     data_grant;
  logic                     data_ack;
  logic [XLEN-1:0]          data_read_data;

  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic                     mem_read_en;
  logic [3:0]               mem_write_en;
  logic [XLEN-1:0]          mem_write_data;
  logic [XLEN-1:0]          mem_read_data;
  logic                     mem_read_ack;
  logic                     mem_write_ack;

  modport master (
    input  fetch_req, fetch_addr,
    input  data_read_en, data_write_en, data_addr, data_write_data,
    input  mem_read_data, mem_read_ack, mem_write_ack,
    output fetch_grant, fetch_ack, fetch_data,
    output data_grant, data_ack, data_read_data,
    output mem_addr, mem_read_en, mem_write_en, mem_write_data
  );

  modport slave (
    output fetch_req, fetch_addr,
    output data_read_en, data_write_en, data_addr, data_write_data,
    output mem_read_data, mem_read_ack, mem_write_ack,
    input  fetch_grant, fetch_ack, fetch_data,
    input  data_grant, data_ack, data_read_data,
    input  mem_addr, mem_read_en, mem_write_en, mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging the fetch and load/store ports onto one mem_controller port,
// one outstanding transaction at a time, with a watchdog on lost acks.
module mem_port_arbiter #(
  parameter int unsigned MEM_ADDR_BITS  = 16,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  mem_port_arbiter_if.master bus,
  output logic               timeout_err
);
  localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;

  state_e                   state_q, state_d;
  owner_e                   owner_q, owner_d;
  logic                     last_data_q, last_data_d;
  logic                     is_store_q, is_store_d;
  logic [WD_W-1:0]          wd_cnt_q, wd_cnt_d;
  logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]          mem_wdata_q, mem_wdata_d;
  logic                     mem_rd_q, mem_rd_d;
  logic [3:0]               mem_we_q, mem_we_d;
  logic [XLEN-1:0]          fetch_data_q, fetch_data_d;
  logic [XLEN-1:0]          data_rdata_q, data_rdata_d;
  logic                     timeout_q, timeout_d;

  logic            active_c, fetch_pend_c, data_pend_c, pick_data_c, grant_c;
  logic            done_c, wd_fire_c, finish_c, fetch_ack_c, data_ack_c, data_load_c;
  logic [XLEN-1:0] fin_data_c, fetch_data_c, data_rdata_c;

  // Arbitration: on contention the port that did not win last time goes first.
  always_comb begin
    active_c     = reset_n & ~sync_reset;
    fetch_pend_c = bus.fetch_req;
    data_pend_c  = bus.data_read_en | (|bus.data_write_en);
    pick_data_c  = data_pend_c & (~fetch_pend_c | ~last_data_q);
    grant_c      = active_c & (state_q == IDLE) & (fetch_pend_c | data_pend_c);
  end

  // Completion: a real ack wins over a watchdog expiry in the same cycle.
  always_comb begin
    done_c       = (state_q == WAIT) & (bus.mem_read_ack | bus.mem_write_ack);
    wd_fire_c    = (state_q == WAIT) & ~done_c & (wd_cnt_q == WD_LAST);
    finish_c     = active_c & (done_c | wd_fire_c);
    fin_data_c   = wd_fire_c ? '0 : bus.mem_read_data;
    fetch_ack_c  = finish_c & (owner_q == OWN_FETCH);
    data_ack_c   = finish_c & (owner_q == OWN_DATA);
    data_load_c  = data_ack_c & (~is_store_q | wd_fire_c);
    fetch_data_c = fetch_ack_c ? fin_data_c : fetch_data_q;
    data_rdata_c = data_load_c ? fin_data_c : data_rdata_q;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_data_d  = last_data_q;
    is_store_d   = is_store_q;
    wd_cnt_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = 1'b0;
    mem_we_d     = 4'b0000;
    fetch_data_d = fetch_data_c;
    data_rdata_d = data_rdata_c;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE: begin
        if (grant_c) begin
          state_d     = ISSUE;
          last_data_d = pick_data_c;
          if (pick_data_c) begin
            owner_d     = OWN_DATA;
            is_store_d  = |bus.data_write_en;
            mem_addr_d  = bus.data_addr;
            mem_wdata_d = bus.data_write_data;
            mem_rd_d    = bus.data_read_en & ~(|bus.data_write_en);
            mem_we_d    = bus.data_write_en;
          end else begin
            owner_d     = OWN_FETCH;
            is_store_d  = 1'b0;
            mem_addr_d  = bus.fetch_addr;
            mem_wdata_d = '0;
            mem_rd_d    = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (finish_c) begin
          state_d   = IDLE;
          owner_d   = OWN_NONE;
          timeout_d = timeout_q | wd_fire_c;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (sync_reset) begin
      state_d      = IDLE;
      owner_d      = OWN_NONE;
      last_data_d  = 1'b0;
      is_store_d   = 1'b0;
      wd_cnt_d     = '0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      mem_rd_d     = 1'b0;
      mem_we_d     = 4'b0000;
      fetch_data_d = '0;
      data_rdata_d = '0;
      timeout_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      last_data_q  <= 1'b0;
      is_store_q   <= 1'b0;
      wd_cnt_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_data_q  <= last_data_d;
      is_store_q   <= is_store_d;
      wd_cnt_q     <= wd_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_we_q     <= mem_we_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.fetch_grant    = grant_c & ~pick_data_c;
  assign bus.data_grant     = grant_c & pick_data_c;
  assign bus.fetch_ack      = fetch_ack_c;
  assign bus.data_ack       = data_ack_c;
  assign bus.fetch_data     = fetch_data_c;
  assign bus.data_read_data = data_rdata_c;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_read_en    = mem_rd_q;
  assign bus.mem_write_en   = mem_we_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign timeout_err        = timeout_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: inputs change 1ns after posedge,
// outputs are sampled on the negedge.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned XL = 32;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic sync_reset;
  logic timeout_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if #(.MEM_ADDR_BITS(AW), .XLEN(XL)) bus ();

  mem_port_arbiter #(.MEM_ADDR_BITS(AW), .XLEN(XL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .bus(bus), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic mem_ack(input logic rd, input logic wr, input logic [XL-1:0] d);
    bus.mem_read_ack  = rd;
    bus.mem_write_ack = wr;
    bus.mem_read_data = d;
  endtask

  task automatic clr_in();
    bus.fetch_req       = 1'b0;
    bus.fetch_addr      = '0;
    bus.data_read_en    = 1'b0;
    bus.data_write_en   = 4'b0000;
    bus.data_addr       = '0;
    bus.data_write_data = '0;
    mem_ack(1'b0, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL tb_time_limit got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic bad;
    int   found;
    logic [XL-1:0] got_data;

    // Reset with a request already pending: nothing may be granted.
    reset_n = 1'b0; sync_reset = 1'b0; clr_in();
    bus.fetch_req = 1'b1; bus.fetch_addr = 12'h3FF;
    smp();
    chk("rst_fetch_grant", 64'(bus.fetch_grant), 64'd0);
    chk("rst_mem_addr",    64'(bus.mem_addr), 64'd0);
    chk("rst_mem_rd",      64'(bus.mem_read_en), 64'd0);
    chk("rst_timeout",     64'(timeout_err), 64'd0);
    chk("rst_fetch_data",  64'(bus.fetch_data), 64'd0);
    cyc(); clr_in(); reset_n = 1'b1;
    cyc();

    // Single fetch, SRAM latency: grant T, issue T+1, ack T+3.
    bus.fetch_req = 1'b1; bus.fetch_addr = 12'h010;
    smp();
    chk("f1_grant",  64'(bus.fetch_grant), 64'd1);
    chk("f1_dgrant", 64'(bus.data_grant), 64'd0);
    cyc(); bus.fetch_req = 1'b0;
    smp();
    chk("f1_issue_rd",   64'(bus.mem_read_en), 64'd1);
    chk("f1_issue_addr", 64'(bus.mem_addr), 64'h010);
    chk("f1_issue_we",   64'(bus.mem_write_en), 64'd0);
    cyc(); smp();
    chk("f1_wait_rd",   64'(bus.mem_read_en), 64'd0);
    chk("f1_wait_addr", 64'(bus.mem_addr), 64'h010);
    cyc(); mem_ack(1'b1, 1'b0, 32'hDEADBEEF);
    smp();
    chk("f1_ack",      64'(bus.fetch_ack), 64'd1);
    chk("f1_data",     64'(bus.fetch_data), 64'hDEADBEEF);
    chk("f1_data_ack", 64'(bus.data_ack), 64'd0);
    cyc(); mem_ack(1'b0, 1'b0, '0);
    smp();
    chk("f1_ack_pulse", 64'(bus.fetch_ack), 64'd0);
    chk("f1_data_hold", 64'(bus.fetch_data), 64'hDEADBEEF);

    // Synchronous reset suppresses a grant and clears held data.
    cyc(); sync_reset = 1'b1; bus.fetch_req = 1'b1;
    smp();
    chk("srst_grant", 64'(bus.fetch_grant), 64'd0);

    // Contention right after reset: data first, then alternate.
    cyc(); sync_reset = 1'b0;
    bus.fetch_addr = 12'h100; bus.data_read_en = 1'b1; bus.data_addr = 12'h200;
    smp();
    chk("srst_fetch_data", 64'(bus.fetch_data), 64'd0);
    chk("rr1_dgrant", 64'(bus.data_grant), 64'd1);
    chk("rr1_fgrant", 64'(bus.fetch_grant), 64'd0);
    cyc(); bus.data_read_en = 1'b0;
    smp();
    chk("rr1_addr",   64'(bus.mem_addr), 64'h200);
    chk("rr1_fgrant_busy", 64'(bus.fetch_grant), 64'd0);
    cyc();
    cyc(); mem_ack(1'b1, 1'b0, 32'hA5A50001);
    smp();
    chk("rr1_dack",  64'(bus.data_ack), 64'd1);
    chk("rr1_ddata", 64'(bus.data_read_data), 64'hA5A50001);
    chk("rr1_fack",  64'(bus.fetch_ack), 64'd0);
    cyc(); mem_ack(1'b0, 1'b0, '0); bus.data_read_en = 1'b1; bus.data_addr = 12'h204;
    smp();
    chk("rr2_fgrant", 64'(bus.fetch_grant), 64'd1);
    chk("rr2_dgrant", 64'(bus.data_grant), 64'd0);
    cyc(); bus.fetch_req = 1'b0;
    smp();
    chk("rr2_addr", 64'(bus.mem_addr), 64'h100);
    cyc();
    cyc(); mem_ack(1'b1, 1'b0, 32'h00000011);
    smp();
    chk("rr2_fdata", 64'(bus.fetch_data), 64'h11);
    cyc(); mem_ack(1'b0, 1'b0, '0); bus.fetch_req = 1'b1; bus.fetch_addr = 12'h104;
    smp();
    chk("rr3_dgrant", 64'(bus.data_grant), 64'd1);
    chk("rr3_fgrant", 64'(bus.fetch_grant), 64'd0);
    cyc(); bus.data_read_en = 1'b0;
    smp();
    chk("rr3_addr", 64'(bus.mem_addr), 64'h204);
    cyc();
    cyc(); mem_ack(1'b1, 1'b0, 32'h00000022);
    smp();
    chk("rr3_ddata", 64'(bus.data_read_data), 64'h22);
    cyc(); mem_ack(1'b0, 1'b0, '0);
    smp();
    chk("rr4_fgrant", 64'(bus.fetch_grant), 64'd1);
    cyc(); bus.fetch_req = 1'b0;
    cyc();
    cyc(); mem_ack(1'b1, 1'b0, 32'h00000033);
    smp();
    chk("rr4_fack", 64'(bus.fetch_ack), 64'd1);
    cyc(); mem_ack(1'b0, 1'b0, '0);

    // Store with read_en also high: issued as a store, ack leaves read data unchanged.
    bus.data_write_en = 4'b0011; bus.data_read_en = 1'b1;
    bus.data_addr = 12'h020; bus.data_write_data = 32'h12345678;
    smp();
    chk("st_dgrant", 64'(bus.data_grant), 64'd1);
    cyc(); clr_in();
    smp();
    chk("st_we",    64'(bus.mem_write_en), 64'h3);
    chk("st_rd",    64'(bus.mem_read_en), 64'd0);
    chk("st_wdata", 64'(bus.mem_write_data), 64'h12345678);
    chk("st_addr",  64'(bus.mem_addr), 64'h020);
    cyc(); mem_ack(1'b0, 1'b1, 32'hFFFF0000);
    smp();
    chk("st_we_pulse", 64'(bus.mem_write_en), 64'd0);
    chk("st_dack",     64'(bus.data_ack), 64'd1);
    chk("st_rdata",    64'(bus.data_read_data), 64'h22);
    chk("st_fack",     64'(bus.fetch_ack), 64'd0);
    cyc(); mem_ack(1'b0, 1'b0, '0);

    // DRAM load with 37-cycle latency, fetch held; stray ack in ISSUE ignored.
    bus.data_read_en = 1'b1; bus.data_addr = 12'h030;
    smp();
    chk("dr_dgrant", 64'(bus.data_grant), 64'd1);
    cyc(); bus.data_read_en = 1'b0; bus.fetch_req = 1'b1; bus.fetch_addr = 12'h040;
    mem_ack(1'b1, 1'b0, 32'h00000BAD);
    smp();
    chk("dr_stray_dack", 64'(bus.data_ack), 64'd0);
    cyc(); mem_ack(1'b0, 1'b0, '0);
    bad = 1'b0;
    for (int i = 0; i < 36; i++) begin
      smp();
      bad = bad | bus.fetch_grant | bus.data_grant | bus.mem_read_en | bus.data_ack;
      cyc();
    end
    chk("dr_no_issue", 64'(bad), 64'd0);
    mem_ack(1'b1, 1'b1, 32'hCAFEF00D);
    smp();
    chk("dr_dack",   64'(bus.data_ack), 64'd1);
    chk("dr_ddata",  64'(bus.data_read_data), 64'hCAFEF00D);
    chk("dr_fgrant_early", 64'(bus.fetch_grant), 64'd0);
    cyc(); mem_ack(1'b0, 1'b0, '0);
    smp();
    chk("dr_fgrant", 64'(bus.fetch_grant), 64'd1);
    chk("dr_single_ack", 64'(bus.data_ack), 64'd0);
    cyc(); bus.fetch_req = 1'b0;
    smp();
    chk("dr_faddr", 64'(bus.mem_addr), 64'h040);
    cyc();
    cyc(); mem_ack(1'b1, 1'b0, 32'h00000044);
    smp();
    chk("dr_fdata", 64'(bus.fetch_data), 64'h44);
    cyc(); mem_ack(1'b0, 1'b0, '0);

    // Lost ack: watchdog fires on the TO-th WAIT cycle with data 0.
    bus.fetch_req = 1'b1; bus.fetch_addr = 12'h050;
    smp();
    chk("to_fgrant", 64'(bus.fetch_grant), 64'd1);
    cyc(); bus.fetch_req = 1'b0;
    cyc();
    found = -1; got_data = '1;
    for (int k = 0; k < 100; k++) begin
      smp();
      if (bus.fetch_ack) begin
        found = k;
        got_data = bus.fetch_data;
        break;
      end
      cyc();
    end
    chk("to_cycle", 64'(found), 64'(TO - 1));
    chk("to_data",  64'(got_data), 64'd0);
    cyc(); bus.data_read_en = 1'b1; bus.data_addr = 12'h060;
    smp();
    chk("to_err",      64'(timeout_err), 64'd1);
    chk("to_ack_once", 64'(bus.fetch_ack), 64'd0);
    chk("to_next_grant", 64'(bus.data_grant), 64'd1);
    cyc(); bus.data_read_en = 1'b0;
    smp();
    chk("to_next_addr", 64'(bus.mem_addr), 64'h060);
    cyc();
    cyc(); mem_ack(1'b1, 1'b0, 32'h00000066);
    smp();
    chk("to_next_ddata", 64'(bus.data_read_data), 64'h66);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
    cyc(); mem_ack(1'b0, 1'b0, '0);

    // Async reset in WAIT, then a stray ack: no ack, everything cleared, back in IDLE.
    bus.fetch_req = 1'b1; bus.fetch_addr = 12'h070;
    smp();
    chk("rm_fgrant", 64'(bus.fetch_grant), 64'd1);
    cyc(); bus.fetch_req = 1'b0;
    cyc(); reset_n = 1'b0;
    smp();
    chk("rm_addr",    64'(bus.mem_addr), 64'd0);
    chk("rm_err",     64'(timeout_err), 64'd0);
    chk("rm_fdata",   64'(bus.fetch_data), 64'd0);
    chk("rm_ddata",   64'(bus.data_read_data), 64'd0);
    cyc(); reset_n = 1'b1; mem_ack(1'b1, 1'b0, 32'h00000099);
    smp();
    chk("rm_stray_fack", 64'(bus.fetch_ack), 64'd0);
    chk("rm_stray_dack", 64'(bus.data_ack), 64'd0);
    cyc(); mem_ack(1'b0, 1'b0, '0); bus.fetch_req = 1'b1; bus.fetch_addr = 12'h07C;
    smp();
    chk("rm_idle_grant", 64'(bus.fetch_grant), 64'd1);
    chk("rm_idle_rd",    64'(bus.mem_read_en), 64'd0);
    cyc(); clr_in();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
